spi_rx_capture: RTL and testbench

SPI receive-side capture block that sits directly downstream of the GCD result transmitter and consumes its three-wire output: chip select, serial clock and serial data. It oversamples the SPI lines in the system clock domain and reassembles MSB-first bytes. Completed bytes go into a small FIFO, which a consumer such as a display or result checker drains through a valid/ready handshake.

---
 rtl/spi_rx_capture_if.sv | 11 +
 rtl/spi_rx_capture.sv | 167 ++++++++++++++++
 tb/tb_spi_rx_capture.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rx_capture_if.sv
// Consumer-side handshake for spi_rx_capture: head-of-FIFO data with valid/ready.
interface spi_rx_capture_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/spi_rx_capture.sv
// Oversampling SPI receiver: synchronizes sclk/cs_n/mosi, rebuilds MSB-first words, queues them in a FIFO.
// Optional partial-frame detection on frame_err is built when SPI_RX_FRAME_CHECK_EN is defined.
module spi_rx_capture #(
    parameter int DATA_W      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sclk_in,
    input  logic             cs_n_in,
    input  logic             mosi_in,
    spi_rx_capture_if.master rx,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, settle;
    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_d, cs_d, armed;
    logic                   sclk_rise_p0, cs_fall_p0, cs_rise_p0, mosi_p0;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Stage p0: synchronizers and registered edge pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync    <= '0;
            cs_sync      <= '1;
            mosi_sync    <= '0;
            settle       <= '0;
            sclk_d       <= 1'b0;
            cs_d         <= 1'b1;
            armed        <= 1'b0;
            sclk_rise_p0 <= 1'b0;
            cs_fall_p0   <= 1'b0;
            cs_rise_p0   <= 1'b0;
        end else begin
            sclk_sync    <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            cs_sync      <= {cs_sync[SYNC_STAGES-2:0], cs_n_in};
            mosi_sync    <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            settle       <= {settle[SYNC_STAGES-2:0], 1'b1};
            sclk_d       <= sclk_s;
            cs_d         <= cs_s;
            // A frame already open when reset releases must not look like a fresh cs_n fall.
            armed        <= armed | (settle[SYNC_STAGES-1] & cs_s);
            sclk_rise_p0 <= sclk_s & ~sclk_d;
            cs_fall_p0   <= armed & cs_d & ~cs_s;
            cs_rise_p0   <= ~cs_d & cs_s;
        end
    end

    always_ff @(posedge clk) begin
        mosi_p0 <= mosi_s;
    end

    state_t              state;
    logic [CW-1:0]       bit_cnt, cnt_next;
    logic [DATA_W-1:0]   shreg, word_next, push_data_p1;
    logic                word_done, push_p1;

    always_comb begin
        word_done = (state == SHIFT) && sclk_rise_p0 && (bit_cnt == LAST_BIT);
        word_next = {shreg[DATA_W-2:0], mosi_p0};
        cnt_next  = bit_cnt;
        if (sclk_rise_p0)
            cnt_next = (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end

    // Stage p1: frame FSM and word assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
            push_p1 <= 1'b0;
        end else begin
            push_p1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (cs_fall_p0) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    bit_cnt <= cnt_next;
                    push_p1 <= word_done;
                    // The bit arriving with cs_n rise is taken first, then the frame closes.
                    if (cs_rise_p0) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && cs_fall_p0)
            shreg <= '0;
        else if (state == SHIFT && sclk_rise_p0)
            shreg <= word_next;
        if (word_done)
            push_data_p1 <= word_next;
    end

    assign busy = (state == SHIFT);

`ifdef SPI_RX_FRAME_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            frame_err <= 1'b0;
        else
            frame_err <= (state == SHIFT) && cs_rise_p0 && (cnt_next != '0);
    end
`else
    assign frame_err = 1'b0;
`endif

    // Stage p2: receive FIFO with registered head
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr, wr_next, rd_next;
    logic              full, pop, push_ok;
    logic [DATA_W-1:0] head_next;

    always_comb begin
        full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        pop       = rx.rx_valid && rx.rx_ready;
        push_ok   = push_p1 && (!full || pop);
        rd_next   = rd_ptr + (AW+1)'(pop);
        wr_next   = wr_ptr + (AW+1)'(push_ok);
        // Bypass the memory when the incoming word lands in the slot becoming head.
        head_next = (push_ok && rd_next == wr_ptr) ? push_data_p1 : mem[rd_next[AW-1:0]];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx.rx_valid <= 1'b0;
            rx.rx_data  <= '0;
            overflow    <= 1'b0;
        end else begin
            wr_ptr      <= wr_next;
            rd_ptr      <= rd_next;
            rx.rx_valid <= (wr_next != rd_next);
            if (wr_next != rd_next)
                rx.rx_data <= head_next;
            if (push_p1 && full && !pop)
                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr[AW-1:0]] <= push_data_p1;
    end
endmodule

// File: tb/tb_spi_rx_capture.sv
// Scoreboard bench for spi_rx_capture: SPI frames are driven bit by bit, expected words are queued
// from the frame contents, and a monitor compares every accepted rx_data against that queue.
module tb_spi_rx_capture;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int SS     = 2;
    localparam int HALF   = 6;

    logic clk = 1'b0;
    logic rst, sclk, cs_n, mosi;
    logic busy, overflow, frame_err;
    logic rand_mode = 1'b0;

    spi_rx_capture_if #(.DATA_W(DATA_W)) rx_if ();

    spi_rx_capture #(.DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
        .clk(clk), .rst(rst), .sclk_in(sclk), .cs_n_in(cs_n), .mosi_in(mosi),
        .rx(rx_if), .busy(busy), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fe_cnt = 0;
    logic [DATA_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every accepted word must be the oldest expected one
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) fe_cnt++;
            if (rx_if.rx_valid && rx_if.rx_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %0h, expected none", rx_if.rx_data);
                end else begin
                    check("rx_data", {56'd0, rx_if.rx_data}, {56'd0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_mode) rx_if.rx_ready = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic sbit(input logic b);
        sclk = 1'b0;
        mosi = b;
        cycles(HALF);
        sclk = 1'b1;
        cycles(HALF);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        cycles(6);
    endtask

    task automatic cs_high();
        sclk = 1'b0;
        cycles(HALF);
        cs_n = 1'b1;
        cycles(10);
    endtask

    task automatic send_bits(input logic [63:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) sbit(data[nbits-1-i]);
    endtask

    // Reference: whole words of the frame in send order, up to 'keep' of them survive.
    task automatic frame(input logic [63:0] data, input int nbits, input int keep);
        int fe0;
        int nw;
        logic [DATA_W-1:0] w;
        nw = nbits / DATA_W;
        for (int i = 0; i < nw && i < keep; i++) begin
            w = data[nbits-1-DATA_W*i -: DATA_W];
            exp_q.push_back(w);
        end
        fe0 = fe_cnt;
        cs_low();
        check("busy_in_frame", {63'd0, busy}, 64'd1);
        send_bits(data, nbits);
        cs_high();
        check("busy_after_frame", {63'd0, busy}, 64'd0);
`ifdef SPI_RX_FRAME_CHECK_EN
        check("frame_err_pulses", 64'(fe_cnt - fe0), 64'((nbits % DATA_W) != 0));
`else
        check("frame_err_pulses", 64'(fe_cnt - fe0), 64'd0);
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_rx_valid"}, {63'd0, rx_if.rx_valid}, 64'd0);
        check({tag, "_rx_data"}, {56'd0, rx_if.rx_data}, 64'd0);
        check({tag, "_busy"}, {63'd0, busy}, 64'd0);
        check({tag, "_overflow"}, {63'd0, overflow}, 64'd0);
        check({tag, "_frame_err"}, {63'd0, frame_err}, 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        rst = 1'b1;
        sclk = 1'b0;
        cs_n = 1'b1;
        mosi = 1'b0;
        rx_if.rx_ready = 1'b0;
        cycles(3);
        check_idle_outputs("reset");
        rst = 1'b0;
        cycles(4);

        // Single word 0x2A, latency from final raw sclk rise to rx_valid
        rx_if.rx_ready = 1'b1;
        exp_q.push_back(8'h2A);
        cs_low();
        send_bits(64'h2A >> 1, 7);
        sclk = 1'b0;
        mosi = 1'b0;
        cycles(HALF);
        sclk = 1'b1;
        for (k = 1; k <= 20; k++) begin
            cycles(1);
            if (rx_if.rx_valid) break;
        end
        check("latency_in_4_to_6", 64'((k >= 4) && (k <= 6)), 64'd1);
        cycles(1);
        check("rx_valid_one_cycle", {63'd0, rx_if.rx_valid}, 64'd0);
        cs_high();
        check("busy_after_2a", {63'd0, busy}, 64'd0);

        // Fill FIFO exactly, then drain on consecutive cycles
        rx_if.rx_ready = 1'b0;
        frame(64'h0180FF00, 32, 99);
        check("full_rx_valid", {63'd0, rx_if.rx_valid}, 64'd1);
        check("full_no_overflow", {63'd0, overflow}, 64'd0);
        @(posedge clk); #1;
        rx_if.rx_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            check("drain_back_to_back", {63'd0, rx_if.rx_valid}, 64'd1);
        end
        @(negedge clk);
        check("drain_empty", {63'd0, rx_if.rx_valid}, 64'd0);
        cycles(2);

        // Fifth word dropped, overflow sticky until reset
        rx_if.rx_ready = 1'b0;
        frame(64'h0180FF0055, 40, DEPTH);
        check("overflow_set", {63'd0, overflow}, 64'd1);
        rx_if.rx_ready = 1'b1;
        cycles(10);
        check("overflow_drained_queue", 64'(exp_q.size()), 64'd0);
        check("overflow_sticky", {63'd0, overflow}, 64'd1);
        do_reset();
        check("overflow_cleared", {63'd0, overflow}, 64'd0);

        // FIFO full, pop coincides with the fifth push
        rx_if.rx_ready = 1'b0;
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        exp_q.push_back(8'h00); exp_q.push_back(8'hA5);
        cs_low();
        send_bits(64'h0180FF00, 32);
        send_bits(64'hA5 >> 1, 7);
        sclk = 1'b0;
        mosi = 1'b1;
        cycles(HALF);
        sclk = 1'b1;
        cycles(4);
        rx_if.rx_ready = 1'b1;
        cycles(HALF - 4);
        cs_high();
        cycles(10);
        check("simul_push_pop_queue", 64'(exp_q.size()), 64'd0);
        check("simul_push_pop_no_ovf", {63'd0, overflow}, 64'd0);

        // Partial frame then a clean one
        frame(64'b10110, 5, 99);
        frame(64'hC3, 8, 99);

        // Reset in mid-frame, frame still open when reset releases
        begin
            int fe0;
            fe0 = fe_cnt;
            cs_low();
            send_bits(64'hB, 4);
            rst = 1'b1;
            cycles(1);
            check_idle_outputs("midreset");
            cycles(2);
            rst = 1'b0;
            send_bits(64'h5, 4);
            cs_high();
            check("midreset_no_push", 64'(exp_q.size()), 64'd0);
            check("midreset_busy", {63'd0, busy}, 64'd0);
            check("midreset_no_frame_err", 64'(fe_cnt - fe0), 64'd0);
        end
        frame(64'h9E, 8, 99);

        // Randomized frames with a randomly stalling consumer
        rand_mode = 1'b1;
        for (int f = 0; f < 8; f++) begin
            logic [63:0] d;
            int nb;
            d  = {$urandom, $urandom};
            nb = $urandom_range(1, 32);
            frame(d, nb, 99);
        end
        rand_mode = 1'b0;
        rx_if.rx_ready = 1'b1;

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            cycles(1);
            k++;
        end
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);
        check("final_no_overflow", {63'd0, overflow}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
